// File: rtl/lemmings_pkg.sv
// Shared definitions for the lemming bridge logic.
//   state_t           : bridge arbiter FSM encoding (also exposed on dbg_state)
//   DIR_LEFT/RIGHT    : walk direction encoding shared with the walker FSMs
package lemmings_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CROSS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/lemmings_bridge_arbiter_rr_pick.sv
// Round-robin pick: finds the first set bit of req scanning from ptr upward,
// wrapping modulo N. Purely combinational.
//   req    : request vector
//   ptr    : index with highest priority this round
//   any    : at least one request is set
//   winner : index of the selected requester (0 when any=0)
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] winner
);

  always_comb begin
    int idx;
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/lemmings_bridge_arbiter.sv
// Single-lane bridge arbiter for N_LEM walking lemmings.
//   clk, rst_n     : clock, asynchronous active-low reset
//   req, dir_in    : per-lemming request and walk direction (1=right)
//   halt           : blocks new grants; a running crossing still completes
//   grant, busy    : one-hot registered grant, held CROSS_CYCLES cycles
//   bridge_dir     : direction of the crosser, latched at grant
//   cross_done     : one-cycle pulse in the gap after a crossing
//   done_id        : index of the lemming that just finished
//   total_crossed  : wrapping count of completed crossings
//   dbg_state      : current FSM state
//
// Handshake: a lemming holds req until it sees its grant bit; the grant then
// stays high for exactly CROSS_CYCLES cycles regardless of req, dir_in or halt.
// Dropping req before the grant simply withdraws the request.
module lemmings_bridge_arbiter
  import lemmings_pkg::*;
#(
  parameter int N_LEM        = 4,
  parameter int CROSS_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_LEM-1:0]         req,
  input  logic [N_LEM-1:0]         dir_in,
  input  logic                     halt,
  output logic [N_LEM-1:0]         grant,
  output logic                     busy,
  output logic                     bridge_dir,
  output logic                     cross_done,
  output logic [$clog2(N_LEM)-1:0] done_id,
  output logic [CNT_W-1:0]         total_crossed,
  output logic [1:0]               dbg_state
);

  localparam int IDW = $clog2(N_LEM);
  localparam int CW  = $clog2(CROSS_CYCLES);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   winner_q, winner_d;
  logic             bridge_dir_q, bridge_dir_d;
  logic [N_LEM-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             cross_done_q, cross_done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [CNT_W-1:0] total_q, total_d;

  logic             pick_any;
  logic [IDW-1:0]   pick_idx;

  rr_pick #(.N(N_LEM), .IDW(IDW)) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .any    (pick_any),
    .winner (pick_idx)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      winner_q     <= '0;
      bridge_dir_q <= 1'b0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      cross_done_q <= 1'b0;
      done_id_q    <= '0;
      total_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      winner_q     <= winner_d;
      bridge_dir_q <= bridge_dir_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      cross_done_q <= cross_done_d;
      done_id_q    <= done_id_d;
      total_q      <= total_d;
    end
  end

  // Next-state decode. Arbitration only happens from IDLE or GAP, so the GAP
  // cycle doubles as the one idle cycle between back-to-back crossings.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    winner_d     = winner_q;
    bridge_dir_d = bridge_dir_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_any && !halt) begin
          state_d      = ST_CROSS;
          cnt_d        = CW'(CROSS_CYCLES - 1);
          winner_d     = pick_idx;
          rr_ptr_d     = (pick_idx == IDW'(N_LEM - 1)) ? '0 : pick_idx + IDW'(1);
          bridge_dir_d = dir_in[pick_idx];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CROSS: begin
        if (cnt_q == '0) state_d = ST_GAP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    grant_d      = '0;
    busy_d       = (state_d == ST_CROSS);
    cross_done_d = (state_d == ST_GAP);
    done_id_d    = done_id_q;
    total_d      = total_q;
    if (state_d == ST_CROSS) grant_d[winner_d] = 1'b1;
    if (state_d == ST_GAP) begin
      done_id_d = winner_q;
      total_d   = total_q + CNT_W'(1);
    end
  end

  assign grant         = grant_q;
  assign busy          = busy_q;
  assign bridge_dir    = bridge_dir_q;
  assign cross_done    = cross_done_q;
  assign done_id       = done_id_q;
  assign total_crossed = total_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_lemmings_bridge_arbiter.sv
module tb_lemmings_bridge_arbiter;

  localparam int N  = 4;
  localparam int CC = 8;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]         req, dir_in;
  logic                 halt;
  logic [N-1:0]         grant;
  logic                 busy, bridge_dir, cross_done;
  logic [$clog2(N)-1:0] done_id;
  logic [CW-1:0]        total_crossed;
  logic [1:0]           dbg_state;

  lemmings_bridge_arbiter #(.N_LEM(N), .CROSS_CYCLES(CC), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .dir_in        (dir_in),
    .halt          (halt),
    .grant         (grant),
    .busy          (busy),
    .bridge_dir    (bridge_dir),
    .cross_done    (cross_done),
    .done_id       (done_id),
    .total_crossed (total_crossed),
    .dbg_state     (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Tracks how many grant cycles remain for the current crosser; zero means
  // the bridge is free and the next edge may hand it out.
  int            m_left, m_who, m_ptr;
  logic [N-1:0]  e_grant;
  logic          e_busy, e_done, e_dir;
  int            e_id;
  logic [CW-1:0] e_total;

  task automatic model_reset();
    m_left = 0; m_who = 0; m_ptr = 0;
    e_grant = '0; e_busy = 0; e_done = 0; e_dir = 0; e_id = 0; e_total = '0;
  endtask

  task automatic model_edge();
    e_done = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        e_done  = 1'b1;
        e_id    = m_who;
        e_total = e_total + 1'b1;
      end
    end else if (!halt && req != '0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (req[i] && m_left == 0) begin
          m_who  = i;
          m_left = CC;
        end
      end
      m_ptr = (m_who + 1) % N;
      e_dir = dir_in[m_who];
    end
    e_busy  = (m_left > 0);
    e_grant = e_busy ? (N'(1) << m_who) : '0;
  endtask

  // Advance one clock; inputs seen at the edge feed the model, outputs are
  // then stable 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; req = '0; dir_in = '0; halt = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    n_vec++;
    if ({grant, busy, bridge_dir, cross_done, done_id, total_crossed, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset: got g=%b b=%b dir=%b d=%b id=%0d t=%0d st=%0d want all zero",
               grant, busy, bridge_dir, cross_done, done_id, total_crossed, dbg_state);
    end
    rst_n = 1;
    repeat (3) cyc();
  endtask

  task automatic test_single();
    dir_in = 4'b0100; req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (c == 0) req = '0;
      n_vec++;
      if ({grant, busy, bridge_dir, cross_done} !== {4'b0100, 1'b1, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL single grant c%0d: got g=%b b=%b dir=%b d=%b want g=0100 b=1 dir=1 d=0",
                 c, grant, busy, bridge_dir, cross_done);
      end
    end
    cyc();
    n_vec++;
    if ({grant, busy, cross_done, done_id, total_crossed} !== {4'b0000, 1'b0, 1'b1, 2'd2, 8'd1}) begin
      n_err++;
      $display("FAIL single gap: got g=%b b=%b d=%b id=%0d t=%0d want g=0000 b=0 d=1 id=2 t=1",
               grant, busy, cross_done, done_id, total_crossed);
    end
    cyc();
    n_vec++;
    if ({grant, busy, cross_done} !== 6'b0) begin
      n_err++;
      $display("FAIL single idle: got g=%b b=%b d=%b want all zero", grant, busy, cross_done);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] prev, want;
    rst_n = 0; #1; model_reset();
    @(posedge clk); #1; rst_n = 1;
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111; prev = '0;
    for (int c = 0; c < 5 * (CC + 1); c++) begin
      cyc();
      n_vec++;
      if ({grant, busy, cross_done, total_crossed} !== {e_grant, e_busy, e_done, e_total}) begin
        n_err++;
        $display("FAIL fair cyc%0d: got g=%b b=%b d=%b t=%0d want g=%b b=%b d=%b t=%0d", c,
                 grant, busy, cross_done, total_crossed, e_grant, e_busy, e_done, e_total);
      end
      if (grant != '0 && prev == '0) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        n_vec++;
        if (grant !== want) begin
          n_err++;
          $display("FAIL fair order: got grant %b want %b", grant, want);
        end
      end
      prev = grant;
    end
    req = '0;
    n_vec++;
    if (total_crossed !== 8'd5 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL fair total: got t=%0d left=%0d want t=5 left=0", total_crossed, exp_q.size());
    end
  endtask

  task automatic test_fair_after();
    cyc();
    req = 4'b0010; dir_in = '0;
    cyc(); req = '0;
    repeat (7) cyc();
    req = 4'b0011;
    cyc(); cyc();
    n_vec++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL fair_after: got grant %b want 0001", grant);
    end
    for (int c = 0; c < 20; c++) begin
      req = req & ~grant;
      cyc();
      n_vec++;
      if ({grant, busy, cross_done, total_crossed} !== {e_grant, e_busy, e_done, e_total}) begin
        n_err++;
        $display("FAIL fair_after cyc%0d: got g=%b b=%b d=%b t=%0d want g=%b b=%b d=%b t=%0d", c,
                 grant, busy, cross_done, total_crossed, e_grant, e_busy, e_done, e_total);
      end
    end
    req = '0;
  endtask

  task automatic test_halt();
    int pulses;
    req = 4'b0001;
    cyc(); req = '0;
    cyc(); cyc();
    halt = 1; req = 4'b1000; pulses = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      pulses += int'(cross_done);
      n_vec++;
      if ({grant, busy, cross_done} !== {e_grant, e_busy, e_done} || grant[3]) begin
        n_err++;
        $display("FAIL halt cyc%0d: got g=%b b=%b d=%b want g=%b b=%b d=%b", c,
                 grant, busy, cross_done, e_grant, e_busy, e_done);
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL halt done: got %0d pulses want 1", pulses);
    end
    halt = 0;
    cyc();
    req = '0;
    n_vec++;
    if (grant !== 4'b1000) begin
      n_err++;
      $display("FAIL halt resume: got grant %b want 1000", grant);
    end
    repeat (9) cyc();
  endtask

  task automatic test_withdraw();
    int g_cnt;
    req = 4'b0010; dir_in = 4'b0010;
    cyc();
    g_cnt = (grant == 4'b0010) ? 1 : 0;
    for (int c = 1; c < 12; c++) begin
      if (c == 2) req[1] = 1'b0;
      if (c == 4) req[2] = 1'b1;
      if (c == 5) req[2] = 1'b0;
      dir_in = N'($urandom);
      cyc();
      if (grant == 4'b0010) g_cnt++;
      n_vec++;
      if ({grant, busy, cross_done} !== {e_grant, e_busy, e_done} || grant[2] ||
          (busy && bridge_dir !== 1'b1)) begin
        n_err++;
        $display("FAIL withdraw cyc%0d: got g=%b b=%b d=%b dir=%b want g=%b b=%b d=%b dir=1", c,
                 grant, busy, cross_done, bridge_dir, e_grant, e_busy, e_done);
      end
    end
    n_vec++;
    if (g_cnt != CC) begin
      n_err++;
      $display("FAIL withdraw hold: got %0d grant cycles want %0d", g_cnt, CC);
    end
  endtask

  task automatic test_async_reset();
    req = 4'b0001;
    cyc(); req = '0;
    repeat (3) cyc();
    #2 rst_n = 0;
    #1;
    n_vec++;
    if ({grant, busy, cross_done, total_crossed} !== '0) begin
      n_err++;
      $display("FAIL async reset: got g=%b b=%b d=%b t=%0d want all zero",
               grant, busy, cross_done, total_crossed);
    end
    model_reset();
    cyc();
    req = 4'b0010; rst_n = 1;
    cyc(); req = '0;
    n_vec++;
    if ({grant, busy, cross_done} !== {4'b0010, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL async restart: got g=%b b=%b d=%b want g=0010 b=1 d=0", grant, busy, cross_done);
    end
    for (int c = 0; c < 10; c++) begin
      cyc();
      n_vec++;
      if ({grant, busy, cross_done, total_crossed} !== {e_grant, e_busy, e_done, e_total}) begin
        n_err++;
        $display("FAIL async after cyc%0d: got g=%b b=%b d=%b t=%0d want g=%b b=%b d=%b t=%0d", c,
                 grant, busy, cross_done, total_crossed, e_grant, e_busy, e_done, e_total);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      req    = N'($urandom);
      dir_in = N'($urandom);
      halt   = ($urandom_range(0, 7) == 0);
      cyc();
      n_vec++;
      if ({grant, busy, cross_done, total_crossed} !== {e_grant, e_busy, e_done, e_total} ||
          (e_busy && bridge_dir !== e_dir) || (e_done && int'(done_id) != e_id)) begin
        n_err++;
        $display("FAIL random cyc%0d: got g=%b b=%b d=%b t=%0d dir=%b id=%0d want g=%b b=%b d=%b t=%0d dir=%b id=%0d",
                 c, grant, busy, cross_done, total_crossed, bridge_dir, done_id,
                 e_grant, e_busy, e_done, e_total, e_dir, e_id);
      end
    end
    halt = 0; req = '0;
  endtask

  task automatic test_wrap();
    bit saw_wrap = 0;
    req = 4'b1111;
    for (int c = 0; c < 2400; c++) begin
      cyc();
      if (cross_done && total_crossed == '0) saw_wrap = 1;
      n_vec++;
      if ({grant, busy, cross_done, total_crossed} !== {e_grant, e_busy, e_done, e_total}) begin
        n_err++;
        $display("FAIL wrap cyc%0d: got g=%b b=%b d=%b t=%0d want g=%b b=%b d=%b t=%0d", c,
                 grant, busy, cross_done, total_crossed, e_grant, e_busy, e_done, e_total);
      end
    end
    req = '0;
    n_vec++;
    if (!saw_wrap) begin
      n_err++;
      $display("FAIL wrap seen: got no 255->0 rollover want one");
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_fair_after();
    test_halt();
    test_withdraw();
    test_async_reset();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
